led_pwm_blinker: RTL

LED_PWM_BLINKER -- requirements
Module: led_pwm_blinker

---
 rtl/led_pwm_pkg.sv | 13 +
 rtl/led_pwm_channel.sv | 112 +++++++++++
 rtl/led_pwm_blinker.sv | 71 +++++++
 3 files changed

// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - shared mode encodings for the LED PWM blinker
// Contents: mode_t enum (MODE_OFF, MODE_STEADY, MODE_BLINK, MODE_FADE),
//           the 2-bit mode field carried in the top bits of a write word.
package led_pwm_pkg;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'b00,
      MODE_STEADY = 2'b01,
      MODE_BLINK  = 2'b10,
      MODE_FADE   = 2'b11
   } mode_t;

endpackage

// File: rtl/led_pwm_channel.sv
// rtl/led_pwm_channel.sv - one LED channel: duty shadow, mode, optional fade, compare
// Ports: clk, reset_n (sync, active low); wr/wdat write this channel's
//        {mode, duty}; pwmctr/wrap/tick/phase come from the shared timebase;
//        pwm is the registered LED drive.
// Fade level logic exists only when LED_PWM_BLINKER_FADE_EN is defined.
module led_pwm_channel
   import led_pwm_pkg::*;
#(
   parameter int PWM_BITS = 3
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                wr,
   input  logic [PWM_BITS+1:0] wdat,
   input  logic [PWM_BITS-1:0] pwmctr,
   input  logic                wrap,
   input  logic                tick,
   input  logic                phase,
   output logic                pwm
);

   mode_t               mode;
   logic [PWM_BITS-1:0] shadow;
   logic [PWM_BITS-1:0] duty;
   logic [PWM_BITS-1:0] shadow_nxt;
   logic [PWM_BITS-1:0] eff_duty;
   logic                enable;

   // A write on the wrap cycle must reach the active register at that wrap,
   // so the active load looks through the shadow at the incoming value.
   assign shadow_nxt = wr ? wdat[PWM_BITS-1:0] : shadow;

   always_comb begin
      enable = 1'b0;
      case (mode)
         MODE_OFF:    enable = 1'b0;
         MODE_STEADY: enable = 1'b1;
         MODE_BLINK:  enable = phase;
         MODE_FADE:   enable = 1'b1;
         default:     enable = 1'b0;
      endcase
   end

`ifdef LED_PWM_BLINKER_FADE_EN
   logic [PWM_BITS-1:0] level;
   logic [PWM_BITS-1:0] level_nxt;
   logic [PWM_BITS-1:0] level_act;
   logic                down;
   logic                down_nxt;

   // Triangle 0 -> all-ones -> 0, one step per blink tick.
   always_comb begin
      level_nxt = level;
      down_nxt  = down;
      if (tick) begin
         if (!down) begin
            if (level == '1) begin
               down_nxt  = 1'b1;
               level_nxt = level - 1'b1;
            end else begin
               level_nxt = level + 1'b1;
            end
         end else begin
            if (level == '0) begin
               down_nxt  = 1'b0;
               level_nxt = level + 1'b1;
            end else begin
               level_nxt = level - 1'b1;
            end
         end
      end
   end

   // The compare uses a level frozen at the wrap so a period is never reshaped.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         level     <= '0;
         down      <= 1'b0;
         level_act <= '0;
      end else begin
         level <= level_nxt;
         down  <= down_nxt;
         if (wrap)
            level_act <= level_nxt;
      end
   end

   assign eff_duty = (mode == MODE_FADE && level_act < duty) ? level_act : duty;
`else
   logic unused_tick;
   assign unused_tick = tick;
   assign eff_duty    = duty;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mode   <= MODE_OFF;
         shadow <= '0;
         duty   <= '0;
         pwm    <= 1'b0;
      end else begin
         if (wr) begin
            mode   <= mode_t'(wdat[PWM_BITS+1 -: 2]);
            shadow <= wdat[PWM_BITS-1:0];
         end
         if (wrap)
            duty <= shadow_nxt;
         pwm <= enable && (pwmctr < eff_duty);
      end
   end

endmodule

// File: rtl/led_pwm_blinker.sv
// rtl/led_pwm_blinker.sv - multi-channel LED PWM with blink, alive LED and optional fade
// Ports: i_clk; i_reset_n (sync, active low); i_stb/i_addr/i_dat write
//        {mode[1:0], duty} to one channel, acked by o_ack one clock later;
//        o_pwm per-channel registered drive; o_alive blink phase.
// Optional fade mode is built only with LED_PWM_BLINKER_FADE_EN defined.
module led_pwm_blinker
   import led_pwm_pkg::*;
#(
   parameter  int NCH           = 3,
   parameter  int PWM_BITS      = 3,
   parameter  int PRESCALE_BITS = 22,
   localparam int ADDR_BITS     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_stb,
   input  logic [ADDR_BITS-1:0] i_addr,
   input  logic [PWM_BITS+1:0]  i_dat,
   output logic                 o_ack,
   output logic [NCH-1:0]       o_pwm,
   output logic                 o_alive
);

   logic [PWM_BITS-1:0]      pwmctr;
   logic [PRESCALE_BITS-1:0] prescale;
   logic                     phase;
   logic                     ack;
   logic                     accept;
   logic                     wrap;
   logic                     tick;

   // While ack is high the strobe is ignored, so a held strobe acks every second clock.
   assign accept  = i_stb && !ack;
   assign wrap    = (pwmctr == '1);
   assign tick    = (prescale == '1);
   assign o_ack   = ack;
   assign o_alive = phase;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         pwmctr   <= '0;
         prescale <= '0;
         phase    <= 1'b0;
         ack      <= 1'b0;
      end else begin
         pwmctr   <= pwmctr + 1'b1;
         prescale <= prescale + 1'b1;
         if (tick)
            phase <= ~phase;
         ack <= accept;
      end
   end

   // Out-of-range addresses match no channel: acked, nothing written.
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      led_pwm_channel #(
         .PWM_BITS(PWM_BITS)
      ) u_ch (
         .clk     (i_clk),
         .reset_n (i_reset_n),
         .wr      (accept && (i_addr == ADDR_BITS'(c))),
         .wdat    (i_dat),
         .pwmctr  (pwmctr),
         .wrap    (wrap),
         .tick    (tick),
         .phase   (phase),
         .pwm     (o_pwm[c])
      );
   end

endmodule
